// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes and default datapath widths.
package noc_pkg;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  localparam int DATA_W = 66;
  localparam int VCH_W  = 2;
  localparam int SEL_W  = 5;
  localparam int CNT_W  = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: +1 per cycle with i_inc, sticks at all-ones.
// Latency 1 cycle; no backpressure (pure sink).
module sat_counter
  import noc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/flit_mux.sv
// Two-port flit mux, one-hot select with port 0 priority, 1-cycle registered output.
// No backpressure; optional forwarded-flit counter under MUX_FLIT_CNT_EN.
module flit_mux
  import noc_pkg::*;
#(
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int VCH_W  = noc_pkg::VCH_W,
  parameter int SEL_W  = noc_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] idata_0,
  input  logic              ivalid_0,
  input  logic [VCH_W-1:0]  ivch_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid_1,
  input  logic [VCH_W-1:0]  ivch_1,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCH_W-1:0]  ovch
`ifdef MUX_FLIT_CNT_EN
  ,
  output logic [31:0]       flit_cnt
`endif
);

  logic              w_sel0;
  logic              w_sel1;
  logic              w_load;
  logic [DATA_W-1:0] w_data;
  logic [VCH_W-1:0]  w_vch;
  logic              w_unused_sel;

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [VCH_W-1:0]  r_vch;

  assign w_sel0       = sel[0];
  assign w_sel1       = ~sel[0] & sel[1];
  assign w_unused_sel = ^sel[SEL_W-1:2];

  assign w_load = (w_sel0 & ivalid_0) | (w_sel1 & ivalid_1);
  assign w_data = w_sel0 ? idata_0 : idata_1;
  assign w_vch  = w_sel0 ? ivch_0  : ivch_1;

  // Data/VC only load with a valid flit so idle cycles do not toggle the link.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_vch   <= '0;
    end else begin
      r_valid <= w_load;
      if (w_load) begin
        r_data <= w_data;
        r_vch  <= w_vch;
      end
    end
  end

  assign odata  = r_data;
  assign ovalid = r_valid;
  assign ovch   = r_vch;

`ifdef MUX_FLIT_CNT_EN
  sat_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_load),
    .o_cnt (flit_cnt)
  );
`endif

endmodule

// File: tb/tb_flit_mux.sv
// Directed self-checking bench for flit_mux; counter checks enabled with MUX_FLIT_CNT_EN.
module tb_flit_mux;
  import noc_pkg::*;

  localparam int DW = 66;
  localparam int VW = 2;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] idata_0, idata_1, odata;
  logic          ivalid_0, ivalid_1, ovalid;
  logic [VW-1:0] ivch_0, ivch_1, ovch;
  logic [SW-1:0] sel;
`ifdef MUX_FLIT_CNT_EN
  logic [31:0]   flit_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] f;

  flit_mux dut (
    .clk      (clk),
    .rst      (rst),
    .idata_0  (idata_0),
    .ivalid_0 (ivalid_0),
    .ivch_0   (ivch_0),
    .idata_1  (idata_1),
    .ivalid_1 (ivalid_1),
    .ivch_1   (ivch_1),
    .sel      (sel),
    .odata    (odata),
    .ovalid   (ovalid),
    .ovch     (ovch)
`ifdef MUX_FLIT_CNT_EN
    ,
    .flit_cnt (flit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    sel      = 5'b00001;
    idata_0  = {TYPE_HEAD, 64'h9};
    ivalid_0 = 1'b1;
    ivch_0   = 2'd2;
    idata_1  = {TYPE_DATA, 64'h77};
    ivalid_1 = 1'b1;
    ivch_1   = 2'd1;

    // Reset held with active inputs
    tick();
    tick();
    chk("rst_odata",  odata,  '0);
    chk("rst_ovalid", {65'd0, ovalid}, '0);
    chk("rst_ovch",   {64'd0, ovch},   '0);
`ifdef MUX_FLIT_CNT_EN
    chk("rst_cnt", {34'd0, flit_cnt}, '0);
`endif

    // First edge after release loads port 0 HEAD
    rst = 1'b0;
    tick();
    chk("p0_head_data",  odata, {TYPE_HEAD, 64'h9});
    chk("p0_head_valid", {65'd0, ovalid}, 66'd1);
    chk("p0_head_vch",   {64'd0, ovch},   66'd2);

    // Port 1 packet: HEAD, 20 DATA, TAIL; port 0 noise must not leak
    sel    = 5'b00010;
    ivch_1 = 2'd1;
    for (int i = 0; i < 22; i++) begin
      if (i == 0)       f = {TYPE_HEAD, 64'h4};
      else if (i == 21) f = {TYPE_TAIL, 64'hFF};
      else              f = {TYPE_DATA, 64'h100 + 64'(i)};
      idata_1  = f;
      ivalid_1 = 1'b1;
      idata_0  = {TYPE_DATA, 64'hDEAD_0000 + 64'(i)};
      ivch_0   = 2'd3;
      tick();
      chk("p1_data",  odata, f);
      chk("p1_valid", {65'd0, ovalid}, 66'd1);
    end
    chk("p1_vch", {64'd0, ovch}, 66'd1);

    // 7-cycle gap on the selected port; outputs hold
    for (int i = 0; i < 7; i++) begin
      ivalid_1 = 1'b0;
      idata_1  = {TYPE_DATA, 64'hBAD0 + 64'(i)};
      ivch_1   = 2'd3;
      tick();
      chk("gap_valid", {65'd0, ovalid}, '0);
      chk("gap_data",  odata, {TYPE_TAIL, 64'hFF});
      chk("gap_vch",   {64'd0, ovch}, 66'd1);
    end
    idata_1  = {TYPE_HEAD, 64'h5};
    ivch_1   = 2'd1;
    ivalid_1 = 1'b1;
    tick();
    chk("head2_data",  odata, {TYPE_HEAD, 64'h5});
    chk("head2_valid", {65'd0, ovalid}, 66'd1);

    // Both select bits set: port 0 wins
    sel      = 5'b00011;
    idata_0  = {TYPE_HEAD, 64'hA};
    ivch_0   = 2'd0;
    ivalid_0 = 1'b1;
    idata_1  = {TYPE_HEAD, 64'hB};
    ivch_1   = 2'd3;
    tick();
    chk("prio_data",  odata, {TYPE_HEAD, 64'hA});
    chk("prio_vch",   {64'd0, ovch}, '0);
    chk("prio_valid", {65'd0, ovalid}, 66'd1);

    // Only ignored select bits set: nothing forwarded
    sel     = 5'b11100;
    idata_0 = {TYPE_DATA, 64'hE};
    tick();
    chk("nosel_valid", {65'd0, ovalid}, '0);
    chk("nosel_data",  odata, {TYPE_HEAD, 64'hA});

    // Async reset mid-packet, cleared without a clock edge
    sel      = 5'b00001;
    idata_0  = {TYPE_DATA, 64'hC};
    ivch_0   = 2'd3;
    ivalid_0 = 1'b1;
    tick();
    chk("pre_ar_data", odata, {TYPE_DATA, 64'hC});
    #2 rst = 1'b1;
    #1;
    chk("ar_data",  odata, '0);
    chk("ar_valid", {65'd0, ovalid}, '0);
    chk("ar_vch",   {64'd0, ovch},   '0);
    tick();
    rst     = 1'b0;
    idata_0 = {TYPE_HEAD, 64'hD};
    tick();
    chk("ar_first_data",  odata, {TYPE_HEAD, 64'hD});
    chk("ar_first_valid", {65'd0, ovalid}, 66'd1);
    chk("ar_first_vch",   {64'd0, ovch}, 66'd3);

`ifdef MUX_FLIT_CNT_EN
    // 10 packets of 22 flits on port 1 from a fresh reset
    rst      = 1'b1;
    sel      = 5'b00010;
    ivalid_0 = 1'b0;
    ivalid_1 = 1'b0;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 22; i++) begin
        idata_1  = {TYPE_DATA, 64'(p * 100 + i)};
        ivalid_1 = 1'b1;
        tick();
      end
    end
    ivalid_1 = 1'b0;
    tick();
    chk("cnt_220", {34'd0, flit_cnt}, 66'd220);

    force dut.u_cnt.r_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.u_cnt.r_cnt;
    ivalid_1 = 1'b1;
    repeat (5) tick();
    ivalid_1 = 1'b0;
    tick();
    chk("cnt_sat", {34'd0, flit_cnt}, {34'd0, 32'hFFFF_FFFF});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_mux.md
# flit_mux

Two-input flit multiplexer for the NoC router output stage. It selects one of two input flit channels (data, valid, virtual channel) with a one-hot port select and drives a single registered output channel. It sits between the router's input buffers and one output link. Its switching activity is characterised for router energy estimation.

## Interface
- DATA_W, default 66: flit width; bits [65:64] hold the flit type, [63:0] the payload.
- VCH_W, default 2: virtual-channel id width.
- SEL_W, default 5: one-hot port-select width (router-wide port count); only bits 0 and 1 are used here.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- idata_0  input  DATA_W  port 0 flit.
- ivalid_0  input  1  port 0 flit valid.
- ivch_0  input  VCH_W  port 0 VC id.
- idata_1  input  DATA_W  port 1 flit.
- ivalid_1  input  1  port 1 flit valid.
- ivch_1  input  VCH_W  port 1 VC id.
- sel  input  SEL_W  one-hot select; bit k selects port k.
- odata  output  DATA_W  selected flit, registered.
- ovalid  output  1  selected valid, registered.
- ovch  output  VCH_W  selected VC id, registered.
- flit_cnt  output  32  forwarded-flit count (present only with MUX_FLIT_CNT_EN).

## Operation
- Port choice: sel[0]=1 selects port 0. Otherwise sel[1]=1 selects port 1. Otherwise no port is selected.
- sel[0] has priority, so sel=2'b11 selects port 0.
- sel bits [SEL_W-1:2] are ignored.
- No port selected: ovalid<=0; odata and ovch hold their values.
- Port selected and its ivalid=1: odata<=idata_k, ovch<=ivch_k, ovalid<=1.
- Port selected and its ivalid=0: ovalid<=0; odata and ovch hold their values. Holding suppresses idle toggling.
- Flit type is not interpreted. HEAD, DATA and TAIL flits pass unchanged.
- No flow control and no backpressure. The downstream stage must accept one flit per cycle.

## Timing
- Latency is exactly 1 cycle, from an input sampled at edge N to the output valid after edge N.
- Throughput is one flit per cycle, with no bubbles on back-to-back flits.
- Reset values: odata=0, ovalid=0, ovch=0, flit_cnt=0.
- Reset is asynchronous. Asserting rst mid-packet clears the outputs immediately, independent of clk.
- The first output update occurs on the first rising edge after rst deasserts.
- A sel change takes effect on the next edge. There is no glitch or partial mix between ports.

## Configuration
- Macro MUX_FLIT_CNT_EN.
- Defined: port flit_cnt exists. flit_cnt increments by 1 on every edge that loads ovalid<=1.
- flit_cnt saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: no flit_cnt port and no counter logic. Datapath behaviour is identical.

## Structure
- Shared package noc_pkg holds:
  - flit type codes: TYPE_NONE=2'b00, TYPE_HEAD=2'b01, TYPE_DATA=2'b10, TYPE_TAIL=2'b11;
  - default widths DATA_W=66, VCH_W=2, SEL_W=5.
- One sub-module, sat_counter: 32-bit saturating counter with increment enable and async reset. It is instantiated only under MUX_FLIT_CNT_EN.

## Test plan
- Reset: assert rst with inputs active -> odata=0, ovalid=0, ovch=0 immediately. After release, the first edge loads the selected input.
- sel=5'b00010, port 1 sends HEAD {2'b01,64'h4}, 20 DATA flits, then TAIL with ivalid_1=1 -> odata matches each flit one cycle later, ovalid=1 for 22 consecutive cycles. Port 0 traffic never appears.
- sel=5'b00001, port 0 HEAD {2'b01,64'h9} -> odata=that flit after 1 cycle, ovch=ivch_0.
- sel=5'b00011 -> port 0 is forwarded (priority). sel=5'b11100 -> ovalid=0 and odata holds its last value.
- Selected ivalid drops to 0 for 7 cycles between packets -> ovalid=0 and odata stable during the gap. The next HEAD appears 1 cycle after ivalid returns to 1.
- With MUX_FLIT_CNT_EN: 10 packets of 22 flits on port 1 -> flit_cnt=220. Force the counter near 32'hFFFF_FFFF and keep sending -> flit_cnt holds at 32'hFFFF_FFFF.
